tdm_sync_filter: RTL and testbench

- Time-multiplexed glitch filter for N_CH slow control/sync inputs. One counter/compare datapath is shared between channels by a round-robin slot scheduler.
- Per-channel state is a filtered level and a mismatch counter; only the active slot's state is updated each cycle.
- Sits between the board input pins and the decode logic. It replaces N separate per-pin filters that each need a 32-bit counter.
- Also provides per-channel one-cycle change strobes.

---
 rtl/tdm_sync_filter.sv | 81 ++++++++
 tb/tb_tdm_sync_filter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_sync_filter.sv
// Round-robin glitch filter: one compare/count datapath shared across N_CH synchronized inputs,
// with per-channel filtered levels, mismatch counters and one-cycle change strobes.
module tdm_sync_filter #(
  parameter  int N_CH          = 4,
  parameter  int FILTER_VISITS = 25,
  parameter  int CNT_W         = 8,
  localparam int SLOT_W        = $clog2(N_CH)
) (
  input  logic              clk_50mhz_in,
  input  logic              reset_in,
  input  logic              enable_in,
  input  logic [N_CH-1:0]   sig_in,
  output logic [N_CH-1:0]   sig_out,
  output logic [N_CH-1:0]   edge_out,
  output logic [SLOT_W-1:0] slot_out
);

  logic [N_CH-1:0]   r_sync1;
  logic [N_CH-1:0]   r_sync2;
  logic [SLOT_W-1:0] r_slot;
  logic [N_CH-1:0]   r_sig;
  logic [N_CH-1:0]   r_edge;
  logic [CNT_W-1:0]  r_cnt [N_CH];

  logic              w_s;
  logic              w_lvl;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_term;
  logic [SLOT_W-1:0] w_slot_nxt;

  // Shared datapath: everything below looks only at the channel in the active slot.
  assign w_s        = r_sync2[r_slot];
  assign w_lvl      = r_sig[r_slot];
  assign w_cnt      = r_cnt[r_slot];
  assign w_term     = (w_cnt >= CNT_W'(FILTER_VISITS));
  assign w_slot_nxt = (r_slot == SLOT_W'(N_CH - 1)) ? '0 : r_slot + SLOT_W'(1);

  assign sig_out  = r_sig;
  assign edge_out = r_edge;
  assign slot_out = r_slot;

  // Synchronizers run every clock so enable_in never stalls input sampling.
  always_ff @(posedge clk_50mhz_in or posedge reset_in) begin
    if (reset_in) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      // NOTE: non-blocking here so r_sync2 takes the old r_sync1, giving two real flop stages.
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk_50mhz_in or posedge reset_in) begin
    if (reset_in) begin
      r_slot <= '0;
      r_sig  <= '0;
      r_edge <= '0;
      // NOTE: the counter array is small and must restart from zero, so it is reset like any flop.
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_edge <= '0;
      if (enable_in) begin
        r_slot <= w_slot_nxt;
        if (w_s == w_lvl) begin
          r_cnt[r_slot] <= '0;
        end else if (w_term) begin
          // Terminal visit clears the counter, so it can never wrap.
          r_sig[r_slot]  <= w_s;
          r_cnt[r_slot]  <= '0;
          r_edge[r_slot] <= 1'b1;
        end else begin
          r_cnt[r_slot] <= w_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_sync_filter.sv
// Scoreboard bench for tdm_sync_filter (N_CH=4, FILTER_VISITS=3, CNT_W=4): stimulus pushes
// hand-computed strobe events, a negedge monitor pops and compares them as edge_out fires.
module tb_tdm_sync_filter;

  localparam int N_CH = 4;

  typedef struct {
    int         cyc;
    logic [3:0] edg;
    logic [3:0] sig;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b1;
  logic [N_CH-1:0]   sig_in = '0;
  logic [N_CH-1:0]   sig_out;
  logic [N_CH-1:0]   edge_out;
  logic [1:0]        slot_out;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q[$];

  tdm_sync_filter #(.N_CH(N_CH), .FILTER_VISITS(3), .CNT_W(4)) dut (
    .clk_50mhz_in (clk),
    .reset_in     (rst),
    .enable_in    (en),
    .sig_in       (sig_in),
    .sig_out      (sig_out),
    .edge_out     (edge_out),
    .slot_out     (slot_out)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges since reset release, as seen at the following negedge.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] e, input logic [3:0] s);
    exp_t x;
    x.cyc = c;
    x.edg = e;
    x.sig = s;
    q.push_back(x);
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Reset asserted mid-cycle so the asynchronous clear is observed before any clock edge.
  task automatic do_reset(input logic [3:0] v);
    #2;
    rst    = 1'b1;
    sig_in = v;
    en     = 1'b1;
    #1;
    check("rst_async_sig", sig_out, 0);
    check("rst_async_edge", edge_out, 0);
    check("rst_async_slot", slot_out, 0);
    check("sb_empty", q.size(), 0);
    q.delete();
    repeat (3) @(negedge clk);
    check("rst_hold_sig", sig_out, 0);
    check("rst_hold_slot", slot_out, 0);
    rst = 1'b0;
  endtask

  // Monitor: every strobe must match the next expected event exactly.
  always @(negedge clk) begin
    if (!rst && edge_out != '0) begin
      if (q.size() == 0) begin
        check("unexpected_edge", edge_out, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("edge_cyc", cyc, e.cyc);
        check("edge_mask", edge_out, e.edg);
        check("edge_sig", sig_out, e.sig);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all inputs high, then all four channels rise from release, one clock apart.
    do_reset(4'hF);
    check("slot_seq_0", slot_out, 0);
    for (int i = 1; i <= 4; i++) begin
      at_cyc(i);
      check("slot_seq", slot_out, i % 4);
    end
    push(15, 4'b0100, 4'b0100);
    push(16, 4'b1000, 4'b1100);
    push(17, 4'b0001, 4'b1101);
    push(18, 4'b0010, 4'b1111);
    at_cyc(24);
    check("all_final", sig_out, 4'hF);

    // Steady change on channel 1: latency 16 clocks (slot 1 visits at 6,10,14,18).
    do_reset(4'h0);
    at_cyc(2);
    sig_in = 4'b0010;
    push(18, 4'b0010, 4'b0010);
    at_cyc(17);
    check("steady_before", sig_out, 0);
    at_cyc(24);
    check("steady_after", sig_out, 4'b0010);

    // Glitch of 10 clocks: only 2 mismatching visits, output stays low.
    do_reset(4'h0);
    at_cyc(2);
    sig_in = 4'b0100;
    at_cyc(12);
    sig_in = 4'b0000;
    at_cyc(20);
    check("glitch_reject", sig_out, 0);
    // 20-clock pulse: rises on the 4th visit (35) only if the count was cleared, falls at 55.
    sig_in = 4'b0100;
    push(35, 4'b0100, 4'b0100);
    push(55, 4'b0100, 4'b0000);
    at_cyc(40);
    check("pulse_high", sig_out, 4'b0100);
    sig_in = 4'b0000;
    at_cyc(60);
    check("pulse_low", sig_out, 0);

    // Enable freeze after 2 mismatching visits of slot 0 (visits 5 and 9).
    do_reset(4'h0);
    at_cyc(2);
    sig_in = 4'b0001;
    at_cyc(10);
    en = 1'b0;
    at_cyc(30);
    check("freeze_slot", slot_out, 2);
    check("freeze_sig", sig_out, 0);
    at_cyc(60);
    check("freeze_slot_end", slot_out, 2);
    check("freeze_sig_end", sig_out, 0);
    en = 1'b1;
    push(67, 4'b0001, 4'b0001);
    at_cyc(61);
    check("resume_slot", slot_out, 3);
    at_cyc(66);
    check("resume_before", sig_out, 0);
    at_cyc(72);
    check("resume_after", sig_out, 4'b0001);

    // Reset mid-operation with sig_out=0101 and channel 3 two visits into its count.
    do_reset(4'h0);
    at_cyc(2);
    sig_in = 4'b0101;
    push(17, 4'b0001, 4'b0001);
    push(19, 4'b0100, 4'b0101);
    at_cyc(6);
    sig_in = 4'b1101;
    at_cyc(19);
    check("midop_pre", sig_out, 4'b0101);
    do_reset(4'b1101);
    // Channel 3 needs a full 4 visits again (4,8,12,16), not the 2 it had left.
    push(15, 4'b0100, 4'b0100);
    push(16, 4'b1000, 4'b1100);
    push(17, 4'b0001, 4'b1101);
    at_cyc(24);
    check("midop_final", sig_out, 4'b1101);
    check("sb_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
